// File: rtl/sram_bus_arbiter_2x1.sv
// -----------------------------------------------------------------------------
// sram_bus_arbiter_2x1
//
// Shares one sram-like slave port between the instruction-fetch master (inst_*)
// and the data master (data_*). Exactly one transaction is outstanding at a
// time; each one walks IDLE (grant) -> ADDR (address phase) -> DATA (data
// phase) -> IDLE.
//
// Handshake semantics (all *_req / *_addr_ok / *_data_ok pairs):
//   A master raises req with stable wr/size/addr/wdata and holds them until
//   the cycle in which its addr_ok is 1; that cycle is the address handshake.
//   data_ok is a single-cycle pulse completing the transaction; rdata is only
//   meaningful in that cycle. On the slave side mem_req/mem_addr_ok and
//   mem_data_ok follow the same rules, with mem_req driven from registers.
//
// Arbitration:
//   default build        : data has priority; after STARVE_LIMIT consecutive
//                          data grants with inst waiting, inst is forced.
//   ARB_ROUND_ROBIN_EN   : when both request, the master that did not own the
//                          previous transaction wins (data wins first).
//
// Ports:
//   clk, resetn                        clock, asynchronous active-low reset
//   inst_req/wr/size/addr/wdata        inst master request fields (in)
//   inst_rdata/addr_ok/data_ok         inst master responses (out)
//   data_req/wr/size/addr/wdata        data master request fields (in)
//   data_rdata/addr_ok/data_ok         data master responses (out)
//   mem_req/wr/size/addr/wdata         slave request, registered (out)
//   mem_rdata/addr_ok/data_ok          slave responses (in)
//   state_dbg                          FSM state: 0=IDLE, 1=ADDR, 2=DATA
// -----------------------------------------------------------------------------
module sram_bus_arbiter_2x1 #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,

    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t state;
    logic   owner;       // 0 = inst, 1 = data; holds the last owner between transactions
    logic   grant_data;  // arbitration result, only consumed in IDLE
    logic   any_req;

    assign any_req = inst_req | data_req;

`ifdef ARB_ROUND_ROBIN_EN
    // owner still names the previous transaction's master while in IDLE, so it
    // doubles as the last-owner register. It resets to inst, so data wins first.
    always_comb begin
        grant_data = data_req;
        if (inst_req && data_req) begin
            grant_data = ~owner;
        end
    end
`else
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] streak_cnt;

    always_comb begin
        grant_data = data_req;
        if (inst_req && data_req) begin
            grant_data = (streak_cnt != LIMIT);
        end
    end

    // Counts data grants that bypassed a waiting inst request. Any grant that
    // does not starve inst (inst grant, or data grant with inst idle) clears it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            streak_cnt <= '0;
        end else if (state == IDLE && any_req) begin
            if (grant_data && inst_req) begin
                if (streak_cnt != '1) begin
                    streak_cnt <= streak_cnt + 1'b1;
                end
            end else begin
                streak_cnt <= '0;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            owner     <= 1'b0;
            mem_req   <= 1'b0;
            mem_wr    <= 1'b0;
            mem_size  <= 2'd0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner     <= grant_data;
                        mem_req   <= 1'b1;
                        mem_wr    <= grant_data ? data_wr    : inst_wr;
                        mem_size  <= grant_data ? data_size  : inst_size;
                        mem_addr  <= grant_data ? data_addr  : inst_addr;
                        mem_wdata <= grant_data ? data_wdata : inst_wdata;
                        state     <= ADDR;
                    end
                end
                ADDR: begin
                    // mem_data_ok is not expected here and is ignored.
                    if (mem_addr_ok) begin
                        mem_req <= 1'b0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (mem_data_ok) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // Handshakes are forwarded combinationally to the owner only.
    assign inst_addr_ok = (state == ADDR) && !owner && mem_addr_ok;
    assign data_addr_ok = (state == ADDR) &&  owner && mem_addr_ok;
    assign inst_data_ok = (state == DATA) && !owner && mem_data_ok;
    assign data_data_ok = (state == DATA) &&  owner && mem_data_ok;

    // Read data is broadcast; each master qualifies it with its own data_ok.
    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

    assign state_dbg = state;

endmodule

// File: tb/tb_sram_bus_arbiter_2x1.sv
`timescale 1ns/1ps
module tb_sram_bus_arbiter_2x1;

    localparam int STARVE_LIMIT = 4;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic        inst_addr_ok, inst_data_ok;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        data_addr_ok, data_data_ok;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [1:0]  state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    sram_bus_arbiter_2x1 #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(4)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .state_dbg(state_dbg)
    );

    // ---------------- reference model / slave state ----------------
    bit          m_busy, m_phase, m_owner, m_last;
    int          m_streak;
    logic        e_wr;
    logic [1:0]  e_size;
    logic [31:0] e_addr, e_wdata;
    bit          s_data_pend;
    int          s_data_wait, s_addr_wait;
    logic [1:0]  exp_q[$];
    logic [1:0]  got_q[$];

    typedef struct {
        logic [31:0] addr, wdata, rdata;
        logic        wr;
        logic [1:0]  size;
        logic        mreq_addr, mreq_data;
        logic        own_aok, oth_aok, own_dok, oth_dok;
        logic [1:0]  end_state;
    } obs_t;

    task automatic init_model();
        m_busy = 0; m_phase = 0; m_owner = 0; m_last = 0; m_streak = 0;
        s_data_pend = 0; s_data_wait = 0; s_addr_wait = $urandom_range(0, 2);
    endtask

    task automatic clear_inputs();
        inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
        mem_rdata = 0; mem_addr_ok = 0; mem_data_ok = 0;
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        clear_inputs();
        init_model();
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    // ---------------- driver tasks ----------------
    // One directed transaction: grant cycle, addr_lat wait cycles, addr_ok,
    // data_lat wait cycles, data_ok, one trailing cycle. Returns observations.
    task automatic drive_txn(input logic is_data, input logic wr, input logic [1:0] size,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input int addr_lat,
                             input int data_lat, output obs_t o);
        @(posedge clk); #1;
        if (is_data) begin
            data_req = 1; data_wr = wr; data_size = size; data_addr = addr; data_wdata = wdata;
        end else begin
            inst_req = 1; inst_wr = wr; inst_size = size; inst_addr = addr; inst_wdata = wdata;
        end
        mem_addr_ok = 0; mem_data_ok = 0;
        @(negedge clk);
        for (int k = 0; k <= addr_lat; k++) begin
            @(posedge clk); #1;
            mem_addr_ok = (k == addr_lat);
            @(negedge clk);
            if (k == addr_lat) begin
                o.addr = mem_addr; o.wdata = mem_wdata; o.wr = mem_wr; o.size = mem_size;
                o.mreq_addr = mem_req;
                o.own_aok = is_data ? data_addr_ok : inst_addr_ok;
                o.oth_aok = is_data ? inst_addr_ok : data_addr_ok;
            end
        end
        for (int k = 0; k <= data_lat; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                mem_addr_ok = 0;
                if (is_data) data_req = 0; else inst_req = 0;
            end
            mem_data_ok = (k == data_lat);
            mem_rdata   = (k == data_lat) ? rdata : $urandom;
            @(negedge clk);
            if (k == 0) o.mreq_data = mem_req;
            if (k == data_lat) begin
                o.own_dok = is_data ? data_data_ok : inst_data_ok;
                o.oth_dok = is_data ? inst_data_ok : data_data_ok;
                o.rdata   = is_data ? data_rdata : inst_rdata;
            end
        end
        @(posedge clk); #1;
        mem_data_ok = 0;
        @(negedge clk);
        o.end_state = state_dbg;
    endtask

    // Random two-master traffic against a random-latency slave. The model
    // tracks the transaction in flight and decides each grant from the
    // arbitration rules; every cycle the DUT's outputs are scored against it.
    task automatic run_traffic(input int ncyc, input int p_i, input int p_d, input bit record);
        bit gen, i_acc, d_acc, win;
        i_acc = 0; d_acc = 0;
        for (int c = 0; c < ncyc + 60; c++) begin
            gen = (c < ncyc);
            @(posedge clk); #1;
            if (!inst_req || i_acc) begin
                inst_req = gen && ($urandom_range(0, 99) < p_i);
                inst_wr = ($urandom_range(0, 9) == 0); inst_size = 2'($urandom_range(0, 2));
                inst_addr = $urandom; inst_wdata = $urandom;
            end
            if (!data_req || d_acc) begin
                data_req = gen && ($urandom_range(0, 99) < p_d);
                data_wr = 1'($urandom_range(0, 1)); data_size = 2'($urandom_range(0, 2));
                data_addr = $urandom; data_wdata = $urandom;
            end
            mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = $urandom;
            if (s_data_pend) begin
                if (s_data_wait == 0) begin
                    mem_data_ok = 1; s_data_pend = 0;
                end else s_data_wait--;
            end else if (mem_req) begin
                if (s_addr_wait == 0) begin
                    mem_addr_ok = 1; s_data_pend = 1;
                    s_data_wait = $urandom_range(0, 2); s_addr_wait = $urandom_range(0, 2);
                end else s_addr_wait--;
            end
            @(negedge clk);
            i_acc = inst_addr_ok; d_acc = data_addr_ok;
            if (record) begin
                if (inst_addr_ok) got_q.push_back(2'd0);
                if (data_addr_ok) got_q.push_back(2'd1);
            end
            if (!m_busy) begin
                n_tests++;
                if ({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 5'b0) begin
                    n_fail++;
                    $display("FAIL idle_quiet t=%0t: got req/aok/dok %b required 00000", $time,
                             {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok});
                end
                if (inst_req || data_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                    win = (inst_req && data_req) ? !m_last : data_req;
`else
                    win = (inst_req && data_req) ? (m_streak != STARVE_LIMIT) : data_req;
                    m_streak = (win && inst_req) ? m_streak + 1 : 0;
`endif
                    m_last = win; m_owner = win; m_busy = 1; m_phase = 0;
                    e_wr    = win ? data_wr    : inst_wr;
                    e_size  = win ? data_size  : inst_size;
                    e_addr  = win ? data_addr  : inst_addr;
                    e_wdata = win ? data_wdata : inst_wdata;
                end
            end else if (!m_phase) begin
                n_tests++;
                if ({mem_req, mem_wr, mem_size, mem_addr, mem_wdata} !== {1'b1, e_wr, e_size, e_addr, e_wdata}) begin
                    n_fail++;
                    $display("FAIL addr_phase t=%0t: got %h required %h", $time,
                             {mem_req, mem_wr, mem_size, mem_addr, mem_wdata}, {1'b1, e_wr, e_size, e_addr, e_wdata});
                end
                n_tests++;
                if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !==
                    {!m_owner && mem_addr_ok, m_owner && mem_addr_ok, 2'b00}) begin
                    n_fail++;
                    $display("FAIL addr_hs t=%0t owner=%0d: got %b required %b", $time, m_owner,
                             {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok},
                             {!m_owner && mem_addr_ok, m_owner && mem_addr_ok, 2'b00});
                end
                if (mem_addr_ok) m_phase = 1;
            end else begin
                n_tests++;
                if ({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !==
                    {3'b000, !m_owner && mem_data_ok, m_owner && mem_data_ok}) begin
                    n_fail++;
                    $display("FAIL data_hs t=%0t owner=%0d: got %b required %b", $time, m_owner,
                             {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok},
                             {3'b000, !m_owner && mem_data_ok, m_owner && mem_data_ok});
                end
                if (mem_data_ok) begin
                    n_tests++;
                    if ((m_owner ? data_rdata : inst_rdata) !== mem_rdata) begin
                        n_fail++;
                        $display("FAIL rdata t=%0t: got %h required %h", $time,
                                 m_owner ? data_rdata : inst_rdata, mem_rdata);
                    end
                    m_busy = 0;
                end
            end
            if (!gen && !m_busy && !inst_req && !data_req) break;
        end
        n_tests++;
        if (m_busy || inst_req || data_req) begin
            n_fail++;
            $display("FAIL drain: got busy=%0d reqs=%b required idle", m_busy, {inst_req, data_req});
            clear_inputs();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        // Load non-zero values into the slave registers, then reset in ADDR.
        @(posedge clk); #1;
        inst_req = 1; inst_wr = 1; inst_size = 2; inst_addr = 32'hFFFF_FFFC; inst_wdata = 32'hA5A5_5A5A;
        @(negedge clk);
        @(posedge clk); #1;
        inst_req = 0;
        @(negedge clk);
        n_tests++;
        if (state_dbg !== ST_ADDR || mem_addr !== 32'hFFFF_FFFC) begin
            n_fail++;
            $display("FAIL pre_reset: got state %0d addr %h required 1 fffffffc", state_dbg, mem_addr);
        end
        #2 resetn = 1'b0;
        #1;
        n_tests++;
        if ({state_dbg, mem_req, mem_wr, mem_size, mem_addr, mem_wdata} !== 70'd0) begin
            n_fail++;
            $display("FAIL reset_values: got %h required 0",
                     {state_dbg, mem_req, mem_wr, mem_size, mem_addr, mem_wdata});
        end
        mem_addr_ok = 1; mem_data_ok = 1;
        #1;
        n_tests++;
        if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_hs: got %b required 0000",
                     {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok});
        end
        apply_reset();
    endtask

    task automatic test_inst_read();
        obs_t o;
        drive_txn(1'b0, 1'b0, 2'd2, 32'hBFC0_0000, 32'h0, 32'h3C08_BFC0, 0, 1, o);
        n_tests++;
        if ({o.mreq_addr, o.wr, o.addr} !== {1'b1, 1'b0, 32'hBFC0_0000}) begin
            n_fail++; $display("FAIL ird_addr: got %h required 1_0_bfc00000", {o.mreq_addr, o.wr, o.addr});
        end
        n_tests++;
        if ({o.own_aok, o.oth_aok} !== 2'b10) begin
            n_fail++; $display("FAIL ird_addr_ok: got %b required 10", {o.own_aok, o.oth_aok});
        end
        n_tests++;
        if ({o.own_dok, o.oth_dok, o.mreq_data} !== 3'b100) begin
            n_fail++; $display("FAIL ird_data_ok: got %b required 100", {o.own_dok, o.oth_dok, o.mreq_data});
        end
        n_tests++;
        if (o.rdata !== 32'h3C08_BFC0) begin
            n_fail++; $display("FAIL ird_rdata: got %h required 3c08bfc0", o.rdata);
        end
        n_tests++;
        if (o.end_state !== ST_IDLE) begin
            n_fail++; $display("FAIL ird_end_state: got %0d required 0", o.end_state);
        end
    endtask

    task automatic test_data_write();
        obs_t o;
        drive_txn(1'b1, 1'b1, 2'd2, 32'hBFAF_8000, 32'hDEAD_BEEF, $urandom, 1, 2, o);
        n_tests++;
        if ({o.wr, o.size, o.addr, o.wdata} !== {1'b1, 2'd2, 32'hBFAF_8000, 32'hDEAD_BEEF}) begin
            n_fail++; $display("FAIL dwr_fields: got %h required 1_2_bfaf8000_deadbeef", {o.wr, o.size, o.addr, o.wdata});
        end
        n_tests++;
        if ({o.own_aok, o.oth_aok, o.own_dok, o.oth_dok} !== 4'b1010) begin
            n_fail++; $display("FAIL dwr_hs: got %b required 1010", {o.own_aok, o.oth_aok, o.own_dok, o.oth_dok});
        end
        n_tests++;
        if (o.end_state !== ST_IDLE) begin
            n_fail++; $display("FAIL dwr_end_state: got %0d required 0", o.end_state);
        end
    endtask

    task automatic test_stray_data_ok();
        @(posedge clk); #1;
        mem_data_ok = 1; mem_rdata = $urandom;
        @(negedge clk);
        n_tests++;
        if ({inst_data_ok, data_data_ok, state_dbg} !== {2'b00, ST_IDLE}) begin
            n_fail++; $display("FAIL stray_idle: got %b required 0000", {inst_data_ok, data_data_ok, state_dbg});
        end
        @(posedge clk); #1;
        mem_data_ok = 0;
        data_req = 1; data_wr = 0; data_size = 1; data_addr = 32'h0000_1234; data_wdata = 0;
        @(negedge clk);
        @(posedge clk); #1;
        mem_data_ok = 1;
        @(negedge clk);
        n_tests++;
        if ({inst_data_ok, data_data_ok, state_dbg, mem_req} !== {2'b00, ST_ADDR, 1'b1}) begin
            n_fail++; $display("FAIL stray_addr: got %b required 00011", {inst_data_ok, data_data_ok, state_dbg, mem_req});
        end
        @(posedge clk); #1;
        mem_data_ok = 0;
        @(negedge clk);
        n_tests++;
        if (state_dbg !== ST_ADDR) begin
            n_fail++; $display("FAIL stray_addr_hold: got %0d required 1", state_dbg);
        end
        @(posedge clk); #1;
        mem_addr_ok = 1;
        @(negedge clk);
        @(posedge clk); #1;
        mem_addr_ok = 0; data_req = 0; mem_data_ok = 1;
        @(negedge clk);
        n_tests++;
        if (data_data_ok !== 1'b1) begin
            n_fail++; $display("FAIL stray_finish: got %b required 1", data_data_ok);
        end
        @(posedge clk); #1;
        mem_data_ok = 0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_data();
        obs_t o;
        @(posedge clk); #1;
        inst_req = 1; inst_wr = 0; inst_size = 2; inst_addr = 32'h1000_0040;
        @(negedge clk);
        @(posedge clk); #1;
        mem_addr_ok = 1;
        @(negedge clk);
        @(posedge clk); #1;
        mem_addr_ok = 0; inst_req = 0;
        @(negedge clk);
        n_tests++;
        if (state_dbg !== ST_DATA) begin
            n_fail++; $display("FAIL rst_mid_pre: got %0d required 2", state_dbg);
        end
        #2 resetn = 1'b0;
        #1;
        n_tests++;
        if ({state_dbg, mem_req} !== {ST_IDLE, 1'b0}) begin
            n_fail++; $display("FAIL rst_mid_async: got %b required 000", {state_dbg, mem_req});
        end
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            mem_data_ok = 1;
            @(negedge clk);
            n_tests++;
            if ({inst_data_ok, data_data_ok} !== 2'b00) begin
                n_fail++; $display("FAIL rst_mid_hold: got %b required 00", {inst_data_ok, data_data_ok});
            end
        end
        resetn = 1'b1;
        init_model();
        @(posedge clk); #1;
        mem_data_ok = 1;
        @(negedge clk);
        n_tests++;
        if ({inst_data_ok, data_data_ok} !== 2'b00) begin
            n_fail++; $display("FAIL rst_mid_release: got %b required 00", {inst_data_ok, data_data_ok});
        end
        @(posedge clk); #1;
        mem_data_ok = 0;
        @(negedge clk);
        drive_txn(1'b0, 1'b0, 2'd2, 32'hBFC0_0100, 32'h0, 32'h2408_0001, 1, 0, o);
        n_tests++;
        if ({o.own_aok, o.own_dok, o.rdata, o.end_state} !== {2'b11, 32'h2408_0001, ST_IDLE}) begin
            n_fail++; $display("FAIL rst_mid_next: got %h required 3_24080001_0", {o.own_aok, o.own_dok, o.rdata, o.end_state});
        end
    endtask

    task automatic test_grant_order();
        apply_reset();
        got_q.delete(); exp_q.delete();
        for (int i = 0; i < 10; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_q.push_back((i % 2 == 0) ? 2'd1 : 2'd0);
`else
            exp_q.push_back((i % (STARVE_LIMIT + 1) == STARVE_LIMIT) ? 2'd0 : 2'd1);
`endif
        end
        run_traffic(120, 100, 100, 1'b1);
        n_tests++;
        if (got_q.size() < 10) begin
            n_fail++; $display("FAIL order_count: got %0d grants required >= 10", got_q.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                n_tests++;
                if (got_q[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL order[%0d]: got %0d required %0d (0=inst 1=data)", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        run_traffic(800, 40, 60, 1'b0);
        run_traffic(600, 80, 90, 1'b0);
        run_traffic(300, 100, 20, 1'b0);
    endtask

    // ---------------- main sequence / report ----------------
    initial begin
        resetn = 1'b0;
        apply_reset();
        test_reset();
        test_inst_read();
        test_data_write();
        test_stray_data_ok();
        test_reset_mid_data();
        test_grant_order();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sram_bus_arbiter_2x1.md
Name: sram_bus_arbiter_2x1

Overview:
- Shares one sram-like slave port between the instruction-fetch master and the data master. The slave port is the uncached/conf path in front of the 1x2 data bridge.
- Non-blocking interface, one outstanding transaction.
- FSM sequences each transaction: grant, address phase, data phase.
- Fixed data-over-inst priority with a starvation guard; round-robin is compile-time optional.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while inst_req is pending before inst is forced (legal 1..15).
- CNT_W, 4: width of the starvation counter.

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- inst_req  in  1  inst master request; held until inst_addr_ok
- inst_wr  in  1  write enable (normally 0)
- inst_size  in  2  transfer size: 0=byte, 1=half, 2=word
- inst_addr  in  32  byte address
- inst_wdata  in  32  write data
- inst_rdata  out  32  read data
- inst_addr_ok  out  1  address accepted
- inst_data_ok  out  1  data returned / write done
- data_req, data_wr, data_size, data_addr, data_wdata, data_rdata, data_addr_ok, data_data_ok: same widths and meanings for the data master
- mem_req  out  1  slave request
- mem_wr  out  1  slave write enable
- mem_size  out  2  slave size
- mem_addr  out  32  slave address
- mem_wdata  out  32  slave write data
- mem_rdata  in  32  slave read data
- mem_addr_ok  in  1  slave address handshake
- mem_data_ok  in  1  slave data handshake

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous, active-low (resetn).
- States: IDLE, ADDR, DATA. Owner register: 0=inst, 1=data.
- IDLE:
  - No req: stay.
  - Any req: select owner per arbitration rules, latch that master's wr/size/addr/wdata into mem_* registers, go to ADDR next cycle.
- ADDR:
  - mem_req=1, driven from registers.
  - On mem_addr_ok: owner's addr_ok=mem_addr_ok in the same cycle (combinational), go to DATA.
  - Master still holds req and stable fields that cycle, so registered values match.
- DATA:
  - mem_req=0.
  - On mem_data_ok: owner's data_ok=1 in the same cycle, go to IDLE.
- Non-owner addr_ok and data_ok are always 0. inst_rdata and data_rdata both carry mem_rdata (broadcast); meaningful only with the owner's data_ok.
- Minimum transaction: 1 cycle IDLE grant + 1 cycle ADDR + 1 cycle DATA. Back-to-back grants need one IDLE cycle.
- Slave rule: mem_data_ok never arrives in the same cycle as mem_addr_ok. mem_data_ok seen in IDLE or ADDR is ignored.
- Arbitration (default build):
  - Only one requester: grant it.
  - Both requesting: grant data unless streak_cnt==STARVE_LIMIT, then grant inst.
  - streak_cnt increments (saturating) on each data grant while inst_req=1; clears on any inst grant, and on a data grant with inst_req=0.
- Reset values: state=IDLE, owner=0, streak_cnt=0, mem_req=0, mem_wr=0, mem_size=0, mem_addr=0, mem_wdata=0. All addr_ok/data_ok=0.
- Reset mid-transaction: immediate return to IDLE, outstanding transaction abandoned, no data_ok issued. Slave is reset by the same resetn.
- Master dropping req after grant (protocol violation): transaction still completes to the slave; addr_ok/data_ok still pulse.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - Both requesting in IDLE: grant the master that did not own the last transaction (last_owner register, reset 0 so data wins first).
  - streak_cnt and STARVE_LIMIT unused; counter logic is removed.
- Undefined: fixed data priority with starvation guard, as described above.

Test Plan:
- Single inst read: inst_req=1, addr=0xBFC00000, slave addr_ok 1 cycle later, data_ok 2 cycles after that with rdata=0x3C08BFC0 -> mem_addr=0xBFC00000, mem_wr=0, inst_addr_ok on the slave addr_ok cycle, inst_data_ok with inst_rdata=0x3C08BFC0, data_* handshakes stay 0.
- Data word write: data_req=1, wr=1, size=2, addr=0xBFAF8000, wdata=0xDEADBEEF -> mem_* carry those values in ADDR, data_addr_ok then data_data_ok, back to IDLE.
- Simultaneous req, default build, STARVE_LIMIT=4: both hold req continuously -> grant order D,D,D,D,I,D,D,D,D,I.
- Simultaneous req with ARB_ROUND_ROBIN_EN: both held -> grant order D,I,D,I.
- Reset mid-DATA: resetn low while waiting for data_ok -> mem_req=0 and state IDLE asynchronously; no data_ok pulse after release; next inst_req is served normally.
- Stray mem_data_ok in IDLE and in ADDR -> no data_ok output, state unchanged.
